bw_io_cmos2_pad_ctl: RTL and testbench
======================================

// Module: bw_io_cmos2_pad_ctl
// PURPOSE
//  Core-side endpoint of a CMOS2 bidirectional pad: drives pad oe/data, consumes pad to_core.
//  TX: valid/ready handshake per bit; each bit is held HOLD_CYC cycles.
//      Turnaround guard before the first driven bit and after the last.
//  RX: 2-flop synchroniser, optional glitch filter, edge pulse. Sticky loopback-mismatch flag.
// PARAMETERS
//  TA_CYC    2  turnaround cycles, oe low, before driving and after release (>=1)
//  HOLD_CYC  4  cycles each tx bit is driven on pad_data (>=3)
//  FILT_LEN  3  consecutive equal synced samples needed to update rx_data (>=2)
//  CNT_W     4  counter width; 2**CNT_W > max(TA_CYC, HOLD_CYC, FILT_LEN)
// PORTS
//  clk         in   1  single clock, all state on posedge
//  rst         in   1  synchronous, active-high reset
//  por_l       in   1  power-on reset, active low; forces pad release
//  tx_valid    in   1  tx bit offered
//  tx_data     in   1  tx bit value
//  tx_ready    out  1  tx bit accepted when tx_valid & tx_ready
//  pad_oe      out  1  to pad oe
//  pad_data    out  1  to pad data
//  pad_to_core in   1  from pad receiver (asynchronous)
//  rx_data     out  1  filtered receive value
//  rx_edge     out  1  1-cycle pulse when rx_data changes
//  tx_busy     out  1  FSM not IDLE
//  mis_err     out  1  sticky loopback mismatch
//  mis_clr     in   1  clears mis_err
// BEHAVIOUR
//  Reset (rst=1 at posedge): FSM=IDLE, counters=0.
//   Outputs: pad_oe=0, pad_data=0, tx_ready=0, rx_data=0, rx_edge=0, tx_busy=0, mis_err=0.
//   Sync flops and filter history reset to 0.
//  FSM states IDLE, TA_ON, DRIVE, TA_OFF:
//   IDLE:   tx_ready=1 (when por_l=1). Handshake -> latch bit, go to TA_ON, cnt=0.
//   TA_ON:  oe=0. After TA_CYC cycles go to DRIVE, cnt=0.
//   DRIVE:  oe=1, pad_data=latched bit. Bit is held HOLD_CYC cycles.
//           tx_ready=1 only in the last hold cycle.
//           Handshake in last cycle: latch new bit, stay in DRIVE, cnt=0 (no turnaround).
//           Else at end of hold go to TA_OFF.
//   TA_OFF: oe=0. After TA_CYC cycles go to IDLE.
//  Handshake is accepted only in IDLE and in the last DRIVE cycle.
//   tx_valid may drop without accept; no state change results.
//  Latency: accept in IDLE at cycle t -> pad_oe=1 from cycle t+1+TA_CYC.
//   pad_oe, pad_data and tx_ready are registered except for the por_l gate.
//  por_l=0: pad_oe and tx_ready forced 0 combinationally.
//   At next posedge FSM->IDLE, counters cleared, latched bit discarded. RX path unaffected.
//  rx sync: s1<=pad_to_core, s2<=s1. Synced value is s2.
//  filter: rx_data takes s2 once s2 has been stable FILT_LEN consecutive cycles.
//   Any change restarts the count. Counter saturates.
//   rx_edge=1 for the one cycle after rx_data changes.
//  mismatch: in the last DRIVE hold cycle, if s2 != latched bit, then mis_err<=1.
//   mis_clr and a same-cycle set: set wins. mis_clr alone clears mis_err.
//  rst during any state: immediate return to reset values at that edge; no TA_OFF guard.
// CONFIGURATION
//  CMOS2_PAD_GLITCH_FILT_EN defined:
//   Filter as above. rx_data latency from pad change = 2+FILT_LEN cycles.
//  Undefined:
//   rx_data=s2 registered, latency 3 cycles. FILT_LEN ignored, no filter counter.
//   rx_edge and mismatch unchanged (mismatch always uses s2).
// TESTING
//  1. Reset 3 cycles -> all outputs 0. Then tx_ready=1 with por_l=1.
//  2. Single bit tx_data=1 accepted at cycle 10 (defaults):
//     pad_oe=1, pad_data=1 in cycles 13-16; pad_oe=0 cycles 17-18; IDLE at 19.
//  3. Back-to-back bits 1,0,1 offered continuously:
//     pad_oe stays 1 for 12 cycles, pad_data 1/0/1 for 4 cycles each, single TA_OFF at the end.
//  4. pad_to_core loopback tied to pad_data inverted -> mis_err=1 after the first bit.
//     mis_clr pulse with no tx -> mis_err=0.
//  5. Filter on: 2-cycle glitch on pad_to_core -> rx_data and rx_edge unchanged.
//     Level change held 10 cycles -> rx_data flips 5 cycles after the change, rx_edge 1 pulse.
//  6. por_l=0 mid-DRIVE -> pad_oe=0 same cycle, FSM IDLE next edge.
//     por_l=1 -> fresh handshake restarts with TA_ON.

Source files
------------

// File: rtl/bw_io_cmos2_pad_ctl.sv
// bw_io_cmos2_pad_ctl
//   Core-side endpoint of a CMOS2 bidirectional pad. Serialises single tx
//   bits onto pad_oe/pad_data with a turnaround guard before the first driven
//   bit and after the last, and conditions the asynchronous pad receiver
//   (2-flop synchroniser, optional glitch filter, change pulse, sticky
//   loopback-mismatch flag).
//
//   Optional feature macro: CMOS2_PAD_GLITCH_FILT_EN
//     defined   : rx_data follows the synced input only after FILT_LEN equal samples
//     undefined : rx_data is the synced input registered once (3-cycle latency)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   por_l               power-on reset (active low), releases pad and aborts tx
//   tx_valid/tx_data    offered tx bit, accepted when tx_valid & tx_ready
//   tx_ready            bit accept strobe (IDLE or last hold cycle of DRIVE)
//   pad_oe/pad_data     pad output enable and data
//   pad_to_core         pad receiver (asynchronous)
//   rx_data/rx_edge     conditioned receive value, 1-cycle pulse on change
//   tx_busy             FSM not IDLE
//   mis_err/mis_clr     sticky loopback mismatch flag and its clear
module bw_io_cmos2_pad_ctl #(
  parameter int unsigned TA_CYC   = 2,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic por_l,
  input  logic tx_valid,
  input  logic tx_data,
  output logic tx_ready,
  output logic pad_oe,
  output logic pad_data,
  input  logic pad_to_core,
  output logic rx_data,
  output logic rx_edge,
  output logic tx_busy,
  output logic mis_err,
  input  logic mis_clr
);

  localparam int unsigned MAX_CNT = (TA_CYC > HOLD_CYC)
                                  ? ((TA_CYC > FILT_LEN) ? TA_CYC : FILT_LEN)
                                  : ((HOLD_CYC > FILT_LEN) ? HOLD_CYC : FILT_LEN);

  if (TA_CYC < 1 || HOLD_CYC < 3 || FILT_LEN < 2 || (2 ** CNT_W) <= MAX_CNT) begin : g_bad_param
    $error("bw_io_cmos2_pad_ctl: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] TA_LAST   = CNT_W'(TA_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, TA_ON, DRIVE, TA_OFF} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_q, bit_d;
  logic             pad_oe_q, pad_oe_d;
  logic             pad_data_q, pad_data_d;
  logic             tx_ready_q, tx_ready_d;
  logic             accept, last_hold;

  // por_l gates the registered strobes so the pad is released immediately
  assign tx_ready  = tx_ready_q & por_l;
  assign pad_oe    = pad_oe_q & por_l;
  assign pad_data  = pad_data_q;
  assign tx_busy   = (state_q != IDLE);
  assign accept    = tx_valid & tx_ready;
  assign last_hold = (state_q == DRIVE) && (cnt_q == HOLD_LAST);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= 1'b0;
      pad_oe_q   <= 1'b0;
      pad_data_q <= 1'b0;
      tx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      pad_oe_q   <= pad_oe_d;
      pad_data_q <= pad_data_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    if (!por_l) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = TA_ON;
            cnt_d   = '0;
            bit_d   = tx_data;
          end
        end
        TA_ON: begin
          if (cnt_q == TA_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d = '0;
            if (accept) bit_d = tx_data;   // back-to-back: no turnaround
            else        state_d = TA_OFF;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        TA_OFF: begin
          if (cnt_q == TA_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // outputs registered from the next state so they align with state_q
  always_comb begin
    pad_oe_d   = (state_d == DRIVE);
    pad_data_d = (state_d == DRIVE) & bit_d;
    tx_ready_d = (state_d == IDLE) || ((state_d == DRIVE) && (cnt_d == HOLD_LAST));
  end

  // receive path
  logic s1_q, s2_q;
  logic rx_data_q, rx_data_d;
  logic rx_edge_q;
  logic mis_err_q, mis_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pad_to_core;
      s2_q <= s1_q;
    end
  end

`ifdef CMOS2_PAD_GLITCH_FILT_EN
  localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILT_LEN);

  logic             prev_q;
  logic [CNT_W-1:0] fcnt_q, run_len;

  // run_len counts the current cycle, so the update fires on the
  // FILT_LEN-th equal sample
  always_comb begin
    if (s2_q != prev_q)        run_len = CNT_W'(1);
    else if (fcnt_q >= FILT_MAX) run_len = FILT_MAX;
    else                       run_len = fcnt_q + CNT_W'(1);
    rx_data_d = (run_len >= FILT_MAX) ? s2_q : rx_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      prev_q <= s2_q;
      fcnt_q <= run_len;
    end
  end
`else
  always_comb rx_data_d = s2_q;
`endif

  always_comb begin
    mis_err_d = mis_err_q;
    if (last_hold && (s2_q != bit_q)) mis_err_d = 1'b1;
    else if (mis_clr)                 mis_err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q <= 1'b0;
      rx_edge_q <= 1'b0;
      mis_err_q <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      rx_edge_q <= (rx_data_d != rx_data_q);
      mis_err_q <= mis_err_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_edge = rx_edge_q;
  assign mis_err = mis_err_q;

endmodule

// File: tb/tb_bw_io_cmos2_pad_ctl.sv
// Directed bench for bw_io_cmos2_pad_ctl with default parameters
// (TA_CYC=2, HOLD_CYC=4, FILT_LEN=3). Follows CMOS2_PAD_GLITCH_FILT_EN.
// Cycle k below means the k-th posedge after the accepting cycle; values are
// sampled 1 time unit after that posedge.
module tb_bw_io_cmos2_pad_ctl;

`ifdef CMOS2_PAD_GLITCH_FILT_EN
  localparam int RX_LAT = 5;
  localparam bit FILT   = 1'b1;
`else
  localparam int RX_LAT = 3;
  localparam bit FILT   = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, por_l, tx_valid, tx_data, mis_clr;
  logic tx_ready, pad_oe, pad_data, pad_to_core;
  logic rx_data, rx_edge, tx_busy, mis_err;
  logic rx_drv;
  int   mode;     // 0: rx_drv, 1: pad_data loopback, 2: inverted loopback
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  assign pad_to_core = (mode == 1) ? pad_data : (mode == 2) ? ~pad_data : rx_drv;

  bw_io_cmos2_pad_ctl #(.TA_CYC(2), .HOLD_CYC(4), .FILT_LEN(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .por_l(por_l),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .pad_oe(pad_oe), .pad_data(pad_data), .pad_to_core(pad_to_core),
    .rx_data(rx_data), .rx_edge(rx_edge), .tx_busy(tx_busy),
    .mis_err(mis_err), .mis_clr(mis_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // One bit from IDLE, no further offers; mismatch flag expected at k=6,7,8.
  task automatic tx_one(input logic b, input logic m6, input logic m7, input logic m8);
    tx_valid = 1'b1;
    tx_data  = b;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) tx_valid = 1'b0;
      check($sformatf("oe k=%0d", k), pad_oe, (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) check($sformatf("data k=%0d", k), pad_data, b);
      check($sformatf("ready k=%0d", k), tx_ready, (k == 6 || k == 9));
      check($sformatf("busy k=%0d", k), tx_busy, (k <= 8));
      if (k == 6) check("mis k=6", mis_err, m6);
      if (k == 7) check("mis k=7", mis_err, m7);
      if (k == 8) check("mis k=8", mis_err, m8);
    end
  endtask

  initial begin
    rst = 1'b1; por_l = 1'b1; tx_valid = 1'b0; tx_data = 1'b0;
    mis_clr = 1'b0; rx_drv = 1'b0; mode = 0;

    // 1: reset
    repeat (3) step();
    check("rst oe", pad_oe, 1'b0);
    check("rst data", pad_data, 1'b0);
    check("rst ready", tx_ready, 1'b0);
    check("rst rx", rx_data, 1'b0);
    check("rst edge", rx_edge, 1'b0);
    check("rst busy", tx_busy, 1'b0);
    check("rst mis", mis_err, 1'b0);
    rst = 1'b0;
    step();
    check("idle ready", tx_ready, 1'b1);
    check("idle busy", tx_busy, 1'b0);

    // 2: single bit, clean loopback
    mode = 1;
    repeat (3) step();
    tx_one(1'b1, 1'b0, 1'b0, 1'b0);

    // 3: back-to-back 1,0,1
    tx_valid = 1'b1;
    tx_data  = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      check($sformatf("b2b oe k=%0d", k), pad_oe, (k >= 3 && k <= 14));
      if (k >= 3 && k <= 14)
        check($sformatf("b2b data k=%0d", k), pad_data, (k <= 6 || k >= 11));
      check($sformatf("b2b ready k=%0d", k), tx_ready, (k == 6 || k == 10 || k == 14 || k == 17));
      check($sformatf("b2b busy k=%0d", k), tx_busy, (k <= 16));
      if (k == 6)  tx_data  = 1'b0;
      if (k == 10) tx_data  = 1'b1;
      if (k == 14) tx_valid = 1'b0;
    end
    check("b2b mis", mis_err, 1'b0);

    // 4a: inverted loopback with mis_clr held: set wins, then clear alone
    mode = 2;
    repeat (3) step();
    mis_clr = 1'b1;
    tx_one(1'b1, 1'b0, 1'b1, 1'b0);
    mis_clr = 1'b0;
    // 4b: sticky until a lone mis_clr pulse
    tx_one(1'b1, 1'b0, 1'b1, 1'b1);
    mode = 0;
    rx_drv = 1'b0;
    repeat (4) step();
    check("mis sticky", mis_err, 1'b1);
    mis_clr = 1'b1;
    step();
    mis_clr = 1'b0;
    check("mis cleared", mis_err, 1'b0);
    repeat (6) step();
    check("rx settled", rx_data, 1'b0);

    // 5a: 2-cycle glitch
    rx_drv = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 2) rx_drv = 1'b0;
      check($sformatf("glitch rx k=%0d", k), rx_data, !FILT && (k == 3 || k == 4));
      check($sformatf("glitch edge k=%0d", k), rx_edge, !FILT && (k == 3 || k == 5));
    end
    // 5b: level change held 10 cycles
    rx_drv = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("level rx k=%0d", k), rx_data, (k >= RX_LAT));
      check($sformatf("level edge k=%0d", k), rx_edge, (k == RX_LAT));
    end
    check("rx no mis", mis_err, 1'b0);

    // 6: por_l drop mid-DRIVE
    rx_drv = 1'b0;
    mode = 1;
    repeat (8) step();
    tx_valid = 1'b1;
    tx_data  = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (3) step();
    check("por pre oe", pad_oe, 1'b1);
    por_l = 1'b0;
    #1;
    check("por oe comb", pad_oe, 1'b0);
    check("por ready comb", tx_ready, 1'b0);
    check("por busy same", tx_busy, 1'b1);
    step();
    check("por busy next", tx_busy, 1'b0);
    check("por oe next", pad_oe, 1'b0);
    check("por ready next", tx_ready, 1'b0);
    step();
    por_l = 1'b1;
    #1;
    check("por rel ready", tx_ready, 1'b1);
    check("por rel oe", pad_oe, 1'b0);
    tx_valid = 1'b1;
    tx_data  = 1'b0;
    step();
    tx_valid = 1'b0;
    check("restart busy", tx_busy, 1'b1);
    check("restart ta1", pad_oe, 1'b0);
    step();
    check("restart ta2", pad_oe, 1'b0);
    step();
    check("restart oe", pad_oe, 1'b1);
    check("restart data", pad_data, 1'b0);
    repeat (6) step();
    check("restart idle", tx_busy, 1'b0);
    check("restart mis", mis_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
